// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the LEGv8 pipeline hazard/forwarding control.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   fwd_sel_t  - operand source select (register file, WB result, MEM result)
//   hz_state_t - hazard FSM states (RUN, STALL2)
//   XZR        - register number that reads as zero and never creates a hazard
//   reg_match  - "source s depends on destination d which is written (w)"
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

  // XZR is hard-wired zero, so a dependence through it is never real.
  function automatic logic reg_match(input logic [4:0] s,
                                     input logic [4:0] d,
                                     input logic       w);
    return w && (s == d) && (d != XZR);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forward select for one source register from the MEM/WB destinations.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output is valid whenever inputs are.
//
// Ports:
//   src                          - source register number being read
//   mem_rd/mem_regwrite/mem_memread - destination info of the MEM-stage instruction
//   wb_rd/wb_regwrite            - destination info of the WB-stage instruction
//   sel                          - FWD_MEM, FWD_WB or FWD_REG
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output fwd_sel_t   sel
);

  logic from_mem;
  logic from_wb;

  // A load in MEM has no data yet; the hazard logic stalls for that case,
  // so the MEM path is only offered for ALU results.
  assign from_mem = reg_match(src, mem_rd, mem_regwrite) && !mem_memread;
  assign from_wb  = reg_match(src, wb_rd, wb_regwrite);

  // MEM holds the younger write, so it wins over WB for the same register.
  always_comb begin
    sel = FWD_REG;
    if (from_mem) begin
      sel = FWD_MEM;
    end else if (from_wb) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for the 5-stage LEGv8 pipeline.
// Latency: 0 cycles hazard-to-control (combinational); counters update on next clk edge.
// Backpressure: stalls hold PC and IF/ID and bubble ID/EX; a taken branch flushes IF/ID.
//
// Ports:
//   clk, reset                 - rising-edge clock, async active-high reset
//   id_*                       - ID-stage source registers, use bits, CB flag, branch taken
//   ex_*, mem_*, wb_*          - downstream stage register numbers and control bits
//   pc_en, ifid_en             - write enables (low during a stall)
//   idex_bubble, ifid_flush    - bubble ID/EX on stall, NOP into IF/ID on taken branch
//   fwd_a, fwd_b, fwd_cb       - EX operand A/B and ID CB-compare forward selects
//   stall_cnt, flush_cnt       - saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_is_cb,
  input  logic             id_br_taken,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_cb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic cb_load_ex;
  logic cb_alu_ex;
  logic cb_load_mem;
  logic need_two;
  logic need_one;
  logic stall;
  logic flush;

  // ---------------------------------------------------------------------------
  // Stall requirement (only meaningful in RUN)
  // ---------------------------------------------------------------------------
  assign load_use = ex_memread &&
                    ((id_use_rn && reg_match(id_rn, ex_rd, 1'b1)) ||
                     (id_use_rm && reg_match(id_rm, ex_rd, 1'b1)));

  // CBZ/CBNZ compares in ID, so it needs its operand one stage earlier than
  // an ALU consumer: a load in EX costs two cycles, an ALU result in EX or a
  // load in MEM costs one.
  assign cb_load_ex  = id_is_cb && ex_memread && reg_match(id_rt, ex_rd, 1'b1);
  assign cb_alu_ex   = id_is_cb && !ex_memread &&
                       reg_match(id_rt, ex_rd, ex_regwrite);
  assign cb_load_mem = id_is_cb && reg_match(id_rt, mem_rd, mem_memread);

  // The two-cycle case dominates any coincident one-cycle case.
  assign need_two = cb_load_ex;
  assign need_one = load_use || cb_alu_ex || cb_load_mem;

  // ---------------------------------------------------------------------------
  // FSM and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (need_two) begin
          stall   = 1'b1;
          state_d = STALL2;
        end else if (need_one) begin
          stall   = 1'b1;
        end else begin
          // A branch under a stall is dropped here; it is still presented
          // in ID when the stall ends and is honoured then.
          flush = id_br_taken;
        end
      end
      STALL2: begin
        // Second half of the load->CB stall; hazard inputs are stale here.
        stall   = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc_en       = !stall;
  assign ifid_en     = !stall;
  assign idex_bubble = stall;
  assign ifid_flush  = flush;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;
  fwd_sel_t fwd_cb_sel;

  fwd_unit u_fwd_a (
    .src          (ex_rn),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .src          (ex_rm),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_b_sel)
  );

  fwd_unit u_fwd_cb (
    .src          (id_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_cb_sel)
  );

  assign fwd_a  = fwd_a_sel;
  assign fwd_b  = fwd_b_sel;
  assign fwd_cb = fwd_cb_sel;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a small expected-result queue.
// Latency: checks combinational controls each cycle; counters modelled per edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rn, id_rm, id_rt;
  logic             id_use_rn, id_use_rm, id_is_cb, id_br_taken;
  logic [4:0]       ex_rn, ex_rm, ex_rd;
  logic             ex_regwrite, ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite, mem_memread;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             pc_en, ifid_en, idex_bubble, ifid_flush;
  logic [1:0]       fwd_a, fwd_b, fwd_cb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rt        (id_rt),
    .id_use_rn    (id_use_rn),
    .id_use_rm    (id_use_rm),
    .id_is_cb     (id_is_cb),
    .id_br_taken  (id_br_taken),
    .ex_rn        (ex_rn),
    .ex_rm        (ex_rm),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .fwd_cb       (fwd_cb),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             pc;
    logic             ifid;
    logic             bub;
    logic             fl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [1:0]       fcb;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference counters, advanced at each clock edge from the expected controls.
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_rt = 5'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_is_cb = 1'b0; id_br_taken = 1'b0;
    ex_rn = 5'd0; ex_rm = 5'd0; ex_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  // Inputs are already driven; queue the expectation, compare at the falling
  // edge, then let the rising edge happen and advance the counter model.
  task automatic step(input string tag, input logic pc, input logic ifid,
                      input logic bub, input logic fl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [1:0] fcb);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ifid = ifid; e.bub = bub; e.fl = fl;
    e.fa = fa; e.fb = fb; e.fcb = fcb;
    e.scnt = reset ? '0 : m_stall;
    e.fcnt = reset ? '0 : m_flush;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("%s.pc_en", e.tag),       32'(pc_en),       32'(e.pc));
    chk($sformatf("%s.ifid_en", e.tag),     32'(ifid_en),     32'(e.ifid));
    chk($sformatf("%s.idex_bubble", e.tag), 32'(idex_bubble), 32'(e.bub));
    chk($sformatf("%s.ifid_flush", e.tag),  32'(ifid_flush),  32'(e.fl));
    chk($sformatf("%s.fwd_a", e.tag),       32'(fwd_a),       32'(e.fa));
    chk($sformatf("%s.fwd_b", e.tag),       32'(fwd_b),       32'(e.fb));
    chk($sformatf("%s.fwd_cb", e.tag),      32'(fwd_cb),      32'(e.fcb));
    chk($sformatf("%s.stall_cnt", e.tag),   32'(stall_cnt),   32'(e.scnt));
    chk($sformatf("%s.flush_cnt", e.tag),   32'(flush_cnt),   32'(e.fcnt));
    @(posedge clk);
    if (reset) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (e.bub && m_stall != '1) m_stall = m_stall + 1'b1;
      if (e.fl  && m_flush != '1) m_flush = m_flush + 1'b1;
    end
    #1;
  endtask

  // Absolute run bound in case the clocked sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    // Reset state: RUN equations, counters zero.
    step("reset", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    step("idle0", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // Load-use: LDUR X2 in EX, ADD reading X2 in ID -> one stall.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd2;
    id_rn = 5'd2; id_use_rn = 1'b1;
    step("lu_stall", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    step("lu_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // Load-use through Rm only.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
    id_rm = 5'd9; id_use_rm = 1'b1; id_rn = 5'd9; id_use_rn = 1'b0;
    step("lu_rm", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    // Same registers but no use bits -> no stall.
    id_use_rm = 1'b0;
    step("lu_nouse", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // CBZ X5 behind LDUR X5 -> RUN, STALL2, then forward from WB.
    idle();
    id_is_cb = 1'b1; id_rt = 5'd5;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
    step("cbld_s1", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    // STALL2 ignores inputs, including a taken branch.
    idle();
    id_br_taken = 1'b1;
    step("cbld_s2", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    id_is_cb = 1'b1; id_rt = 5'd5; wb_rd = 5'd5; wb_regwrite = 1'b1;
    step("cbld_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b01);

    // CB with the load in MEM -> one stall, then RUN again.
    idle();
    id_is_cb = 1'b1; id_rt = 5'd6;
    mem_rd = 5'd6; mem_memread = 1'b1; mem_regwrite = 1'b1;
    step("cbmem", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    step("cbmem_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // CB with an ALU write in EX -> one stall.
    id_is_cb = 1'b1; id_rt = 5'd7; ex_rd = 5'd7; ex_regwrite = 1'b1;
    step("cbalu", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    step("cbalu_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // XZR never matches, neither for stalls nor forwarding.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd31;
    id_rn = 5'd31; id_use_rn = 1'b1; id_is_cb = 1'b1; id_rt = 5'd31;
    ex_rn = 5'd31; ex_rm = 5'd31;
    mem_rd = 5'd31; mem_regwrite = 1'b1; wb_rd = 5'd31; wb_regwrite = 1'b1;
    step("xzr", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // Forward priority: MEM over WB, then WB alone, then load in MEM.
    idle();
    mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
    ex_rn = 5'd3; ex_rm = 5'd3; id_rt = 5'd3;
    step("fwd_mem", 1, 1, 0, 0, 2'b10, 2'b10, 2'b10);
    mem_regwrite = 1'b0;
    step("fwd_wb", 1, 1, 0, 0, 2'b01, 2'b01, 2'b01);
    mem_regwrite = 1'b1; mem_memread = 1'b1;
    step("fwd_memld", 1, 1, 0, 0, 2'b01, 2'b01, 2'b01);
    // Mixed operands: A from MEM, B from WB.
    idle();
    mem_rd = 5'd4; mem_regwrite = 1'b1; wb_rd = 5'd8; wb_regwrite = 1'b1;
    ex_rn = 5'd4; ex_rm = 5'd8; id_rt = 5'd1;
    step("fwd_mix", 1, 1, 0, 0, 2'b10, 2'b01, 2'b00);

    // Branch versus stall: stall wins, branch taken the next cycle.
    idle();
    id_br_taken = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd2;
    id_rn = 5'd2; id_use_rn = 1'b1;
    step("br_stall", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    id_br_taken = 1'b1;
    step("br_flush", 1, 1, 0, 1, 2'b00, 2'b00, 2'b00);
    idle();
    step("br_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // Reset while in STALL2: next cycle RUN, counters cleared.
    id_is_cb = 1'b1; id_rt = 5'd5;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
    step("rst_s1", 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    idle();
    reset = 1'b1;
    step("rst_in_s2", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    step("rst_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);

    // Saturation: 20 back-to-back load-use stalls on a 4-bit counter.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd12;
    id_rn = 5'd12; id_use_rn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    end
    idle();
    step("sat_end", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    chk("sat_value", 32'(stall_cnt), 32'h0000000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, stall and forwarding controller for the 5-stage LEGv8 pipeline. It watches register numbers and control bits in ID, EX, MEM and WB, and drives four sets of signals: PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush, and the operand-forward selects. The forward selects cover the EX-stage ALU operands and the ID-stage CBZ/CBNZ compare, which resolves early using the sign-extended 19-bit CB offset. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- `CNT_W`, default 32: width of each performance counter.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `id_rn`, `id_rm`, `id_rt`  in  5 each: source registers of the instruction in ID.
- `id_use_rn`, `id_use_rm`  in  1 each: the ID instruction reads Rn / Rm.
- `id_is_cb`  in  1: the ID instruction is CBZ/CBNZ; it compares `id_rt` in ID.
- `id_br_taken`  in  1: a branch in ID resolves taken this cycle.
- `ex_rn`, `ex_rm`  in  5 each: ALU source registers in EX.
- `ex_rd`  in  5: destination register in EX.
- `ex_regwrite`  in  1: the EX instruction writes a register.
- `ex_memread`  in  1: the EX instruction is a load.
- `mem_rd`  in  5: destination register in MEM.
- `mem_regwrite`, `mem_memread`  in  1 each: MEM write and load flags.
- `wb_rd`  in  5: destination register in WB.
- `wb_regwrite`  in  1: the WB instruction writes a register.
- `pc_en`, `ifid_en`  out  1 each: write enables for the PC and the IF/ID register.
- `idex_bubble`  out  1: zero all ID/EX control bits.
- `ifid_flush`  out  1: load a NOP into IF/ID.
- `fwd_a`, `fwd_b`  out  2 each: EX operand selects.
- `fwd_cb`  out  2: ID compare-operand select.
- `stall_cnt`, `flush_cnt`  out  CNT_W each: performance counters.

## Operation
- **Register 31 (XZR).** A register number of 31 never matches: no hazards, no forwarding.
- **Match.** "Match(s, d, w)" means s == d, w = 1, and d != 31.
- **Stall requirement, computed in state RUN:**
  - Load-use: `ex_memread` and Match(id_rn or id_rm, `ex_rd`) with the matching use bit set → 1 stall cycle.
  - CB with a load in EX: `id_is_cb` and `ex_memread` and Match(`id_rt`, `ex_rd`) → 2 stall cycles.
  - CB with an ALU write in EX: `id_is_cb` and Match(`id_rt`, `ex_rd`, `ex_regwrite`), not a load → 1 stall cycle.
  - CB with a load in MEM: `id_is_cb` and Match(`id_rt`, `mem_rd`, `mem_memread`) → 1 stall cycle.
- **Stall cycle outputs:** `pc_en` = 0, `ifid_en` = 0, `idex_bubble` = 1, `ifid_flush` = 0.
- **FSM states:** RUN, STALL2.
  - RUN with a 2-cycle requirement: stall this cycle (Mealy), next state STALL2.
  - RUN with a 1-cycle requirement: stall this cycle, stay in RUN.
  - STALL2: stall unconditionally, ignore all hazard inputs, next state RUN.
- **Taken branch.** `id_br_taken` is honoured only in RUN with no stall requirement. It drives `ifid_flush` = 1 with `pc_en` = 1 and `ifid_en` = 1 (the PC loads the target). Whenever a stall is asserted, `id_br_taken` is ignored.
- **EX forwarding (`fwd_a`/`fwd_b`)** for `ex_rn`/`ex_rm`:
  - 2'b10 when Match(src, `mem_rd`, `mem_regwrite`) and not `mem_memread`.
  - Otherwise 2'b01 when Match(src, `wb_rd`, `wb_regwrite`).
  - Otherwise 2'b00. MEM has priority over WB.
- **CB forwarding (`fwd_cb`)** for `id_rt`, using the same MEM/WB rules and encoding.
- **Counters.**
  - `stall_cnt` increments on every cycle with `idex_bubble` = 1.
  - `flush_cnt` increments on every cycle with `ifid_flush` = 1.
  - Both saturate at all-ones and do not wrap.

## Timing
- **Reset values:** state = RUN, both counters = 0.
- **Control outputs at and after reset:** they follow the RUN equations combinationally, with no reset-state exception. `pc_en` = 1 and `ifid_en` = 1 whenever no hazard is present.
- **Reset during STALL2:** next state is RUN and no residual stall occurs.
- **Latency:**
  - Hazard to stall/flush outputs: 0 cycles (combinational).
  - Counters update on the following rising edge.
- **Simultaneous CB and load-use stall:** the maximum requirement wins.
- **Simultaneous stall requirement and `id_br_taken`:** the stall wins, and the branch is re-evaluated after the stall ends.
- **Equal MEM and WB destinations:** MEM wins.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - `fwd_sel_t`: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - `hz_state_t`: RUN, STALL2.
  - Constant `XZR` = 5'd31.
- Sub-module `fwd_unit`: purely combinational. It maps one source register plus the MEM/WB destination info to a `fwd_sel_t`, and is instantiated three times (A, B, CB).
- The top level holds the FSM, the stall-requirement logic and the counters.

## Test plan
- Load-use: EX `LDUR X2` (`ex_memread` = 1, `ex_rd` = 2) with ID `ADD` reading `id_rn` = 2 → exactly 1 cycle of `pc_en` = 0 and `idex_bubble` = 1; `stall_cnt` 0 → 1.
- CB after load: EX `LDUR X5` with ID `CBZ` and `id_rt` = 5 → 2 consecutive stall cycles (RUN → STALL2 → RUN), then `fwd_cb` = 2'b01.
- XZR: EX load with `ex_rd` = 31 and ID `id_rn` = 31 → no stall, and `fwd_a` = 2'b00.
- Forward priority: `mem_rd` = `wb_rd` = 3, both writing, `ex_rn` = 3 → `fwd_a` = 2'b10; clear `mem_regwrite` → `fwd_a` = 2'b01.
- Branch versus stall: `id_br_taken` = 1 together with a load-use hazard → a stall with no flush; the next cycle, with `id_br_taken` still 1 → `ifid_flush` = 1 and `flush_cnt` += 1.
- Reset and saturation:
  - Assert `reset` during STALL2 → the next cycle is RUN and the counters are 0.
  - With CNT_W = 4, 20 stall cycles → `stall_cnt` = 4'hF.
